// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result/digit path.
// check_ndig lets instantiating blocks reject digit counts too small for the value width.
package calc_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        ALIGN = 2'd2,
        EMIT  = 2'd3
    } state_t;

    localparam digit_t DIGIT_MAX = 4'd9;

    function automatic bit check_ndig(input int width, input int ndig);
        logic [63:0] v_pow;
        v_pow = 64'd1;
        for (int i = 0; i < ndig; i++) begin
            v_pow = v_pow * 64'd10;
        end
        return (v_pow > ((64'd1 << width) - 64'd1));
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add-3 correction on every BCD nibble, then a
// left shift that brings the next binary bit in at the least significant end.
module bcd_dabble_step
    import calc_pkg::*;
#(
    parameter int NDIG = 5
) (
    input  logic [4*NDIG-1:0] i_bcd,
    input  logic              i_bit,
    output logic [4*NDIG-1:0] o_bcd
);

    logic [4*NDIG-1:0] w_adj;

    // Nibbles of 5 or more would become >= 10 after doubling, so pre-add 3
    always_comb begin
        w_adj = '0;
        for (int n = 0; n < NDIG; n++) begin
            if (i_bcd[4*n +: 4] >= 4'd5) begin
                w_adj[4*n +: 4] = i_bcd[4*n +: 4] + 4'd3;
            end else begin
                w_adj[4*n +: 4] = i_bcd[4*n +: 4];
            end
        end
    end

    assign o_bcd = {w_adj[4*NDIG-2:0], i_bit};

endmodule

// File: rtl/result_digit_serializer.sv
// Converts an unsigned binary result to decimal digits (double-dabble) and emits
// them most significant first over a valid/ready link, skipping leading zeros.
module result_digit_serializer
    import calc_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int NDIG  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_valor,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [3:0]       digito,
    output logic             dig_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (!check_ndig(WIDTH, NDIG)) begin : g_ndig_bad
            $error("result_digit_serializer: NDIG too small to hold 2^WIDTH-1");
        end
    endgenerate

    state_t            r_state;
    logic [WIDTH-1:0]  r_shift;
    logic [4*NDIG-1:0] r_bcd;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic              r_in_ready;
    logic              r_dig_valid;
    digit_t            r_digito;
    logic              r_dig_last;
    logic              r_busy;

    logic [4*NDIG-1:0] w_bcd_next;
    logic [IW-1:0]     w_msd;

    function automatic digit_t nibble_at(input logic [4*NDIG-1:0] bcd, input logic [IW-1:0] idx);
        return bcd[{idx, 2'b00} +: 4];
    endfunction

    bcd_dabble_step #(.NDIG(NDIG)) u_step (
        .i_bcd (r_bcd),
        .i_bit (r_shift[WIDTH-1]),
        .o_bcd (w_bcd_next)
    );

    // Position of the most significant nonzero nibble; 0 when the value is zero
    always_comb begin
        w_msd = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_msd = IW'(i);
            end else begin
                w_msd = w_msd;
            end
        end
    end

    // Control FSM with registered handshake and digit outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_dig_valid <= 1'b0;
            r_digito    <= 4'd0;
            r_dig_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_shift    <= in_valor;
                        r_bcd      <= '0;
                        r_cnt      <= CW'(WIDTH);
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    r_bcd   <= w_bcd_next;
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= ALIGN;
                    end
                end
                ALIGN: begin
                    r_idx       <= w_msd;
                    r_digito    <= nibble_at(r_bcd, w_msd);
                    r_dig_last  <= (w_msd == '0);
                    r_dig_valid <= 1'b1;
                    r_state     <= EMIT;
                end
                EMIT: begin
                    if (dig_ready) begin
                        if (r_idx == '0) begin
                            r_dig_valid <= 1'b0;
                            r_dig_last  <= 1'b0;
                            r_digito    <= 4'd0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_idx      <= r_idx - IW'(1);
                            r_digito   <= nibble_at(r_bcd, r_idx - IW'(1));
                            r_dig_last <= (r_idx == IW'(1));
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_dig_valid <= 1'b0;
                    r_dig_last  <= 1'b0;
                    r_digito    <= 4'd0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign dig_valid = r_dig_valid;
    assign digito    = r_digito;
    assign dig_last  = r_dig_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_result_digit_serializer.sv
// Directed table plus hand-written corner sequences and a random sweep for
// result_digit_serializer; inputs driven and outputs sampled on the falling edge.
module tb_result_digit_serializer;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] in_valor = 14'd0;
    logic        dig_valid;
    logic        dig_ready = 1'b0;
    logic [3:0]  digito;
    logic        dig_last;
    logic        busy;

    int checks = 0;
    int failures = 0;

    result_digit_serializer #(.WIDTH(14), .NDIG(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_valor  (in_valor),
        .dig_valid (dig_valid),
        .dig_ready (dig_ready),
        .digito    (digito),
        .dig_last  (dig_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] val;
        string       exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    // Present a value and wait (bounded) for acceptance; returns at the negedge after the accept edge
    task automatic send(input logic [13:0] v);
        int w;
        w = 0;
        in_valor = v;
        in_valid = 1'b1;
        while (!in_ready && w < 100) begin
            @(posedge clk);
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            chk("send_timeout", 0, 1);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // mode 0: ready always 1; mode 1: ready follows pat per valid cycle; mode 2: random ready
    task automatic recv(input int mode, input logic [15:0] pat, output string s,
                        output int nlast, output int lat);
        int   cyc;
        int   k;
        bit   done;
        bit   stalled;
        logic [3:0] held;
        cyc = 0; k = 0; done = 1'b0; stalled = 1'b0; held = 4'd0;
        s = ""; nlast = 0; lat = -1;
        while (!done && cyc < 300) begin
            if (mode == 0) dig_ready = 1'b1;
            else if (mode == 1) dig_ready = (k < 16) ? pat[k] : 1'b1;
            else dig_ready = 1'($urandom_range(0, 1));
            if (dig_valid) begin
                if (lat < 0) lat = cyc;
                if (stalled) chk("stall_hold", int'(digito), int'(held));
                if (digito > DIGIT_MAX) chk("digit_range", int'(digito), int'(DIGIT_MAX));
                if (dig_ready) begin
                    s = {s, $sformatf("%0d", digito)};
                    if (dig_last) begin
                        nlast++;
                        done = 1'b1;
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = digito;
                end
                k++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            chk("recv_timeout", 0, 1);
        end else begin
            chk("idle_in_ready", int'(in_ready), 1);
            chk("idle_dig_valid", int'(dig_valid), 0);
        end
    endtask

    initial begin
        string s;
        int    nl;
        int    lat;
        logic [13:0] v;

        vecs[0] = '{14'd0,     "0"};
        vecs[1] = '{14'd16383, "16383"};
        vecs[2] = '{14'd9,     "9"};
        vecs[3] = '{14'd10,    "10"};
        vecs[4] = '{14'd100,   "100"};
        vecs[5] = '{14'd9999,  "9999"};
        vecs[6] = '{14'd10000, "10000"};
        vecs[7] = '{14'd4096,  "4096"};
        vecs[8] = '{14'd1005,  "1005"};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_dig_valid", int'(dig_valid), 0);
        chk("rst_dig_last", int'(dig_last), 0);
        chk("rst_digito", int'(digito), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table with dig_ready held high
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].val);
            chk("busy_after_accept", int'(busy), 1);
            recv(0, 16'h0000, s, nl, lat);
            chk_str("table_digits", s, vecs[i].exp);
            chk("table_nlast", nl, 1);
            chk("table_latency", lat, 15);
        end

        // 1040 with a stalling consumer: ready pattern 1,0,0,1,0,1,1
        send(14'd1040);
        recv(1, 16'b0000000001101001, s, nl, lat);
        chk_str("stall_1040", s, "1040");
        chk("stall_1040_nlast", nl, 1);

        // 7, with 99 held on the input while busy
        send(14'd7);
        in_valor = 14'd99;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("busy_in_ready_low", int'(in_ready), 0);
            @(posedge clk);
            @(negedge clk);
        end
        recv(0, 16'h0000, s, nl, lat);
        chk_str("ignored_while_busy", s, "7");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("accept_99_busy", int'(busy), 1);
        recv(0, 16'h0000, s, nl, lat);
        chk_str("after_idle_99", s, "99");
        chk("after_idle_99_lat", lat, 15);

        // 2500, reset right after the "2" handshake
        send(14'd2500);
        dig_ready = 1'b1;
        begin
            int w;
            w = 0;
            while (!dig_valid && w < 50) begin
                @(posedge clk);
                @(negedge clk);
                w++;
            end
            chk("rst_seq_first_valid", int'(dig_valid), 1);
        end
        chk("rst_seq_first_digit", int'(digito), 2);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_dig_valid", int'(dig_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_digito", int'(digito), 0);
        send(14'd31);
        recv(0, 16'h0000, s, nl, lat);
        chk_str("post_rst_31", s, "31");

        // Random sweep with random backpressure
        for (int i = 0; i < 200; i++) begin
            v = 14'($urandom_range(0, 16383));
            send(v);
            recv(2, 16'h0000, s, nl, lat);
            chk_str("rand_digits", s, $sformatf("%0d", v));
            chk("rand_nlast", nl, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
